// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//   Round-robin arbiter and access sequencer that sits in front of a
//   single-port 32-word data memory. The memory reads combinationally and
//   writes on the rising edge. Two requesters share it: the core load/store
//   unit (m0) and a debug/DMA port (m1). Each granted transaction is
//   sequenced onto the memory.
//
//   Stores with partial byte enables are done as a read-modify-write: one
//   read cycle, then one write cycle that carries the merged word. A store
//   with no byte enables set never touches the memory and is acknowledged
//   straight away.
//
//   Every memory-side output is driven from a register, so nothing on the
//   requester inputs reaches the memory combinationally. The one exception
//   is reset: rst_n gates both enables so that a write already in flight is
//   never committed once reset is seen.
//
// Ports:
//   clk                 in   single clock, rising edge
//   rst_n               in   synchronous active-low reset
//   m0_req / m1_req     in   request, held with its fields until ack
//   m0_we / m1_we       in   1 = write, 0 = read
//   m0_addr / m1_addr   in   word address (memory uses [4:0])
//   m0_wdata / m1_wdata in   write data
//   m0_be / m1_be       in   byte enables, bit i covers byte i
//   m0_ack / m1_ack     out  one-cycle completion pulse
//   m0_rdata / m1_rdata out  read data during ack of a read, else 0
//   mem_addr            out  memory address
//   mem_rd_en           out  memory read enable
//   mem_wr_en           out  memory write enable
//   mem_wdata           out  memory write data
//   mem_rdata           in   memory read data
// ---------------------------------------------------------------------------
module dmem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_be,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_be,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ACCESS = 3'd1;
  localparam logic [2:0] RMW_RD = 3'd2;
  localparam logic [2:0] RMW_WR = 3'd3;
  localparam logic [2:0] RESP   = 3'd4;

  logic [2:0]  state_q,    state_d;
  logic        lastM1_q,   lastM1_d;
  logic        gntM1_q,    gntM1_d;
  logic        we_q,       we_d;
  logic [31:0] addr_q,     addr_d;
  logic [31:0] wdata_q,    wdata_d;
  logic [3:0]  be_q,       be_d;
  logic [31:0] rspData_q,  rspData_d;
  logic [31:0] memAddr_q,  memAddr_d;
  logic        memRdEn_q,  memRdEn_d;
  logic        memWrEn_q,  memWrEn_d;
  logic [31:0] memWdata_q, memWdata_d;

  logic        anyReq;
  logic        pickM1;
  logic [31:0] mergedWord;
  logic        nextIsMemState;

  // Round-robin choice between the requesters. With only one requesting,
  // that one wins. With both requesting, the one that was not granted last
  // wins. lastM1_q comes out of reset set, so m0 takes the first tie.
  always_comb begin
    anyReq = m0_req | m1_req;
    pickM1 = 1'b0;
    if (m1_req && !m0_req) begin
      pickM1 = 1'b1;
    end else if (m1_req && m0_req) begin
      pickM1 = !lastM1_q;
    end
  end

  // Byte merge for partial stores. Each enabled byte comes from the latched
  // write data, and each disabled byte comes from the word the memory
  // returns during RMW_RD. The result is only consumed on the RMW_RD ->
  // RMW_WR transition, while mem_rdata holds the addressed word.
  always_comb begin
    mergedWord = '0;
    for (int i = 0; i < 4; i++) begin
      mergedWord[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : mem_rdata[8*i +: 8];
    end
  end

  // Main sequencer. IDLE is the only state that looks at req. It latches the
  // whole transaction and picks the path from the type of access:
  //   - read or full-word store: a single memory cycle
  //   - partial store: read-modify-write
  //   - store with no enables: straight to the response
  always_comb begin
    state_d   = state_q;
    lastM1_d  = lastM1_q;
    gntM1_d   = gntM1_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rspData_d = rspData_q;

    case (state_q)
      IDLE: begin
        if (anyReq) begin
          gntM1_d   = pickM1;
          lastM1_d  = pickM1;
          we_d      = pickM1 ? m1_we    : m0_we;
          addr_d    = pickM1 ? m1_addr  : m0_addr;
          wdata_d   = pickM1 ? m1_wdata : m0_wdata;
          be_d      = pickM1 ? m1_be    : m0_be;
          rspData_d = '0;
          if (!we_d || be_d == 4'b1111) begin
            state_d = ACCESS;
          end else if (be_d == 4'b0000) begin
            state_d = RESP;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      ACCESS: begin
        if (!we_q) begin
          rspData_d = mem_rdata;
        end
        state_d = RESP;
      end
      RMW_RD: begin
        state_d = RMW_WR;
      end
      RMW_WR: begin
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory-side outputs are computed from the state being entered and then
  // registered. This way the registered values line up with the state that
  // uses them in the next cycle. Outside the memory states the address,
  // enables and write data all sit at zero.
  always_comb begin
    nextIsMemState = (state_d == ACCESS) || (state_d == RMW_RD) ||
                     (state_d == RMW_WR);
    memAddr_d  = nextIsMemState ? addr_d : 32'h0;
    memRdEn_d  = ((state_d == ACCESS) && !we_d) || (state_d == RMW_RD);
    memWrEn_d  = ((state_d == ACCESS) && we_d) || (state_d == RMW_WR);
    memWdata_d = 32'h0;
    if ((state_d == ACCESS) && we_d) begin
      memWdata_d = wdata_d;
    end else if (state_d == RMW_WR) begin
      memWdata_d = mergedWord;
    end
  end

  // State and output registers with synchronous reset. Reset drops any
  // transaction in flight without an ack. It also hands the next tie to m0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lastM1_q   <= 1'b1;
      gntM1_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rspData_q  <= '0;
      memAddr_q  <= '0;
      memRdEn_q  <= 1'b0;
      memWrEn_q  <= 1'b0;
      memWdata_q <= '0;
    end else begin
      state_q    <= state_d;
      lastM1_q   <= lastM1_d;
      gntM1_q    <= gntM1_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rspData_q  <= rspData_d;
      memAddr_q  <= memAddr_d;
      memRdEn_q  <= memRdEn_d;
      memWrEn_q  <= memWrEn_d;
      memWdata_q <= memWdata_d;
    end
  end

  // Gating the enables with rst_n means that a reset landing on a write
  // cycle suppresses the write at that same edge. Without it the memory
  // would commit a half-finished transaction.
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign mem_rd_en = memRdEn_q & rst_n;
  assign mem_wr_en = memWrEn_q & rst_n;

  // Ack and read data are decoded from the response state. Only the granted
  // requester sees the pulse, and the read data is zero for stores.
  assign m0_ack   = (state_q == RESP) && !gntM1_q;
  assign m1_ack   = (state_q == RESP) && gntM1_q;
  assign m0_rdata = (m0_ack && !we_q) ? rspData_q : 32'h0;
  assign m1_rdata = (m1_ack && !we_q) ? rspData_q : 32'h0;

endmodule
